// File: rtl/pe_pipelined.sv
// Two-stage pipelined processing element: S1 holds the accepted beat, S2 holds the result.
// DOT beats accumulate into acc and emit a single result on the beat marked in_last.
module pe_pipelined #(
  parameter int WIDTH      = 32,
  parameter int OPCODE_LEN = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OPCODE_LEN-1:0] opcode,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out,
  output logic                  halted
);

  localparam logic [OPCODE_LEN-1:0] OP_ADD  = OPCODE_LEN'(3);
  localparam logic [OPCODE_LEN-1:0] OP_SUB  = OPCODE_LEN'(4);
  localparam logic [OPCODE_LEN-1:0] OP_MUL  = OPCODE_LEN'(5);
  localparam logic [OPCODE_LEN-1:0] OP_DOT  = OPCODE_LEN'(6);
  localparam logic [OPCODE_LEN-1:0] OP_STOP = OPCODE_LEN'(10);

  logic                  r_s1_valid;
  logic [OPCODE_LEN-1:0] r_s1_op;
  logic [WIDTH-1:0]      r_s1_a;
  logic [WIDTH-1:0]      r_s1_b;
  logic                  r_s1_last;
  logic [WIDTH-1:0]      r_acc;
  logic [WIDTH-1:0]      r_out;
  logic                  r_out_valid;
  logic                  r_halted;

  logic                  w_advance;
  logic                  w_accept;
  logic                  w_stop_accept;
  logic                  w_s1_dot;
  logic [WIDTH-1:0]      w_product;
  logic [WIDTH-1:0]      w_result;
  logic                  w_produces;

  assign w_advance     = !r_out_valid || out_ready;
  assign in_ready      = w_advance && !r_halted;
  assign w_accept      = in_valid && in_ready;
  assign w_stop_accept = w_accept && (opcode == OP_STOP);
  assign w_s1_dot      = r_s1_valid && (r_s1_op == OP_DOT);
  assign w_product     = r_s1_a * r_s1_b;

  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign halted    = r_halted;

  // Non-producing opcodes leave w_result at zero so out reads 0 while idle.
  always_comb begin
    w_result   = '0;
    w_produces = 1'b0;
    if (r_s1_valid) begin
      case (r_s1_op)
        OP_ADD: begin
          w_result   = r_s1_a + r_s1_b;
          w_produces = 1'b1;
        end
        OP_SUB: begin
          w_result   = r_s1_a - r_s1_b;
          w_produces = 1'b1;
        end
        OP_MUL: begin
          w_result   = w_product;
          w_produces = 1'b1;
        end
        OP_DOT: begin
          if (r_s1_last) begin
            w_result   = r_acc + w_product;
            w_produces = 1'b1;
          end
        end
        default: begin
          w_result   = '0;
          w_produces = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_op     <= '0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_last   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end else if (w_advance) begin
      r_s1_valid  <= w_accept;
      if (w_accept) begin
        r_s1_op   <= opcode;
        r_s1_a    <= a;
        r_s1_b    <= b;
        r_s1_last <= in_last;
      end
      r_out_valid <= w_produces;
      r_out       <= w_result;
    end
  end

  // STOP clears acc even if a DOT beat is leaving S1 in the same cycle; nothing can follow it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_halted <= 1'b0;
    end else begin
      if (w_stop_accept) begin
        r_halted <= 1'b1;
        r_acc    <= '0;
      end else if (w_advance && w_s1_dot) begin
        r_acc <= r_s1_last ? '0 : (r_acc + w_product);
      end
    end
  end

endmodule
